lcd_bus_receiver: RTL and testbench
===================================

Name: lcd_bus_receiver

Overview:
- Responder end of the character-LCD write bus (lcd_e, lcd_rs, lcd_rw, lcd_data) driven by the text LCD driver.
- Decodes the HD44780-style command subset and captures data writes into a 32-byte display buffer (2 lines x 16).
- Serves as the on-chip mirror for debug readback and as the checking model in system benches.
- Exposes a registered read port plus cursor and status outputs.

Parameters:
- SYNC_STAGES, 2, depth of the input synchroniser chain applied identically to lcd_e, lcd_rs, lcd_rw and lcd_data (legal range 2..4).
- FILL_CHAR, 8'h20, byte written to every buffer location by clear.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- lcd_e  in  1  bus enable; a transfer is accepted on its falling edge.
- lcd_rs  in  1  0 = command, 1 = data.
- lcd_rw  in  1  0 = write, 1 = read (reads are not supported).
- lcd_data  in  8  command or character byte.
- rd_addr  in  5  buffer read index; 0-15 = line 1, 16-31 = line 2.
- rd_data  out  8  buffer byte at rd_addr, registered, 1-cycle latency.
- cursor  out  5  current write index.
- display_on  out  1  display enable state from command 0x08-0x0F, bit 2.
- busy  out  1  high while a clear fill is in progress.
- wr_strobe  out  1  one-cycle pulse for each accepted data write.
- err_overrun  out  1  sticky; a transfer arrived while busy.
- err_read  out  1  sticky; a transfer arrived with lcd_rw=1.

Behaviour:
- Input pipeline: all four bus inputs shift through a SYNC_STAGES-deep register chain in lockstep.
- Transfer detect: a transfer is detected when the last stage of E is 0 and the stage before it is 1. rs, rw and data are taken from the last stage in the same cycle.
- Execute: the transfer executes on the next clock edge. Its effect (buffer, cursor, flags, wr_strobe) is visible SYNC_STAGES+1 cycles after the first clk edge that samples lcd_e low.
- FSM states: RESET_FILL, IDLE, FILL.
- rst (any state, including mid-fill) forces:
  - state RESET_FILL, fill index 0
  - cursor 0, display_on 0, entry direction increment, busy 1
  - err flags 0, wr_strobe 0, rd_data 0, sync chains cleared
- RESET_FILL / FILL:
  - write FILL_CHAR at the fill index, one location per cycle, indices 0..31.
  - After index 31 is written (32 cycles), go to IDLE and deassert busy on the following cycle.
- IDLE, rw=1: transfer ignored, err_read set.
- IDLE, rw=0, rs=1 (data write):
  - buffer[cursor] <= data; wr_strobe pulses.
  - cursor moves by +1 or -1 per entry direction, mod 32 (31+1 -> 0, 0-1 -> 31).
- IDLE, rw=0, rs=0 (command), priority by highest set bit:
  - 0x80-0xFF set address: the 7-bit address A = data[6:0] maps to cursor A for 0x00-0x0F and to 16+(A-0x40) for 0x40-0x4F. Any other A is ignored and cursor is unchanged.
  - 0x20-0x3F function set: accepted, no state change.
  - 0x10-0x1F shift: ignored.
  - 0x08-0x0F: display_on <= data[2].
  - 0x04-0x07: entry direction <= data[1] (1 = increment).
  - 0x02-0x03: cursor <= 0.
  - 0x01 clear: cursor <= 0, entry direction <= increment, enter FILL (busy 1, 32 cycles).
  - 0x00: ignored.
- Any transfer detected while busy=1 is dropped: no buffer, cursor or mode change, no wr_strobe; err_overrun set.
- Error flags clear only on rst.
- Read port:
  - rd_data <= buffer[rd_addr] on every clock, including during fill.
  - Read-during-write to the same index returns the old byte.
- Buffer: 32x8 single write port; contents are defined only after the first fill completes.

Test Plan:
- rst held 1 cycle, then wait 34 cycles -> busy falls after 32 fill cycles; rd_addr 0..31 all return 8'h20; cursor 0; display_on 0; errors 0.
- Write data "WATCH" (57,41,54,43,48) after fill -> buffer[0..4] = 57 41 54 43 48; cursor 5; five wr_strobe pulses, each SYNC_STAGES+1 cycles after its E falling edge.
- Commands 0xC0 then data 0x41 -> buffer[16] = 0x41, cursor 17. Command 0x90 -> cursor stays 17.
- Command 0x04 (decrement), 0x80, then data 0x5A -> buffer[0] = 0x5A, cursor 31. Command 0x06, 0x8F, data 0x31 x2 -> buffer[15] = 0x31, buffer[16] = 0x31, cursor 17.
- Command 0x01, then data 0x41 issued 10 cycles later -> 0x41 dropped, err_overrun = 1; after fill all 32 locations read 8'h20.
- Assert rst at fill cycle 12 -> fill restarts from index 0; busy stays high 32 cycles from reset. A transfer with lcd_rw=1 -> err_read = 1 and the buffer is unchanged.

Source files
------------

// File: rtl/lcd_bus_receiver.sv
// -----------------------------------------------------------------------------
// lcd_bus_receiver
//
// Responder end of the character-LCD write bus. Bus transfers are accepted on
// the falling edge of lcd_e (after synchronisation). The receiver decodes the
// HD44780-style command subset and mirrors data writes into a 32-byte display
// buffer (2 lines x 16). It is used for debug readback and as a checking model.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   lcd_e        bus enable; transfer accepted on its falling edge
//   lcd_rs       0 = command, 1 = data
//   lcd_rw       0 = write, 1 = read (reads are flagged, not served)
//   lcd_data     command or character byte
//   rd_addr      buffer read index (0-15 line 1, 16-31 line 2)
//   rd_data      registered buffer byte at rd_addr, 1-cycle latency
//   cursor       current write index
//   display_on   display enable state
//   busy         high while a clear fill is in progress
//   wr_strobe    one-cycle pulse per accepted data write
//   err_overrun  sticky: transfer arrived while busy
//   err_read     sticky: transfer arrived with lcd_rw = 1
// -----------------------------------------------------------------------------
module lcd_bus_receiver #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  FILL_CHAR   = 8'h20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [4:0] cursor,
  output logic       display_on,
  output logic       busy,
  output logic       wr_strobe,
  output logic       err_overrun,
  output logic       err_read
);

  typedef enum logic [1:0] {
    RESET_FILL,
    IDLE,
    FILL
  } state_t;

  // Bus word layout inside the synchroniser: {e, rs, rw, data[7:0]}
  logic [10:0] sync_reg [SYNC_STAGES];
  logic [10:0] sync_last;
  logic        e_last_d_reg;
  logic        detect;

  logic        xfer_valid_reg;
  logic        xfer_rs_reg;
  logic        xfer_rw_reg;
  logic [7:0]  xfer_data_reg;

  state_t      state_reg;
  logic [4:0]  fill_idx_reg;
  logic        entry_inc_reg;

  logic [7:0]  buffer_mem [32];
  logic        mem_we;
  logic [4:0]  mem_waddr;
  logic [7:0]  mem_wdata;

  // ---------------------------------------------------------------------------
  // Input synchroniser: all four bus signals move through the chain together so
  // rs/rw/data at the chain output belong to the same sample as e.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= '0;
      end
      e_last_d_reg <= 1'b0;
    end else begin
      sync_reg[0] <= {lcd_e, lcd_rs, lcd_rw, lcd_data};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
      e_last_d_reg <= sync_reg[SYNC_STAGES-1][10];
    end
  end

  assign sync_last = sync_reg[SYNC_STAGES-1];

  // Falling edge of the synchronised enable: output now low, previously high.
  assign detect = !sync_last[10] && e_last_d_reg;

  // Capture the detected transfer; it executes on the following edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_valid_reg <= 1'b0;
      xfer_rs_reg    <= 1'b0;
      xfer_rw_reg    <= 1'b0;
      xfer_data_reg  <= 8'h00;
    end else begin
      xfer_valid_reg <= detect;
      if (detect) begin
        xfer_rs_reg   <= sync_last[9];
        xfer_rw_reg   <= sync_last[8];
        xfer_data_reg <= sync_last[7:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM: fill sequencing, command decode, cursor and flags.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= RESET_FILL;
      fill_idx_reg  <= 5'd0;
      cursor        <= 5'd0;
      display_on    <= 1'b0;
      entry_inc_reg <= 1'b1;
      busy          <= 1'b1;
      wr_strobe     <= 1'b0;
      err_overrun   <= 1'b0;
      err_read      <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      case (state_reg)
        RESET_FILL, FILL: begin
          fill_idx_reg <= fill_idx_reg + 5'd1;
          if (fill_idx_reg == 5'd31) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
          // Anything arriving mid-fill is dropped
          if (xfer_valid_reg) begin
            err_overrun <= 1'b1;
          end
        end

        IDLE: begin
          if (xfer_valid_reg) begin
            if (xfer_rw_reg) begin
              err_read <= 1'b1;
            end else if (xfer_rs_reg) begin
              wr_strobe <= 1'b1;
              cursor    <= entry_inc_reg ? cursor + 5'd1 : cursor - 5'd1;
            end else if (xfer_data_reg[7]) begin
              // Set address: line 1 at 0x00-0x0F, line 2 at 0x40-0x4F
              if (xfer_data_reg[6:4] == 3'b000) begin
                cursor <= {1'b0, xfer_data_reg[3:0]};
              end else if (xfer_data_reg[6:4] == 3'b100) begin
                cursor <= {1'b1, xfer_data_reg[3:0]};
              end
            end else if (xfer_data_reg[6:5] != 2'b00) begin
              // Function set: accepted, nothing to track
            end else if (xfer_data_reg[4]) begin
              // Shift: not mirrored
            end else if (xfer_data_reg[3]) begin
              display_on <= xfer_data_reg[2];
            end else if (xfer_data_reg[2]) begin
              entry_inc_reg <= xfer_data_reg[1];
            end else if (xfer_data_reg[1]) begin
              cursor <= 5'd0;
            end else if (xfer_data_reg[0]) begin
              cursor        <= 5'd0;
              entry_inc_reg <= 1'b1;
              fill_idx_reg  <= 5'd0;
              busy          <= 1'b1;
              state_reg     <= FILL;
            end
          end
        end

        default: begin
          state_reg    <= RESET_FILL;
          fill_idx_reg <= 5'd0;
          busy         <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Buffer: single write port shared between the fill sequencer and data
  // writes; the fill owns the port whenever the FSM is not idle.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = cursor;
    mem_wdata = xfer_data_reg;
    if (!rst) begin
      if (state_reg != IDLE) begin
        mem_we    = 1'b1;
        mem_waddr = fill_idx_reg;
        mem_wdata = FILL_CHAR;
      end else if (xfer_valid_reg && !xfer_rw_reg && xfer_rs_reg) begin
        mem_we = 1'b1;
      end
    end
  end

  // Buffer storage has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      buffer_mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered read; a same-cycle write to rd_addr returns the old byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= 8'h00;
    end else begin
      rd_data <= buffer_mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// -----------------------------------------------------------------------------
// tb_lcd_bus_receiver
//
// Drives directed and randomized LCD bus transfers into lcd_bus_receiver and
// compares every output each cycle against a transaction-level model of the
// display mirror, plus literal expectations for the documented scenarios.
// -----------------------------------------------------------------------------
module tb_lcd_bus_receiver;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lcd_e = 1'b0;
  logic       lcd_rs = 1'b0;
  logic       lcd_rw = 1'b0;
  logic [7:0] lcd_data = 8'h00;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_data;
  logic [4:0] cursor;
  logic       display_on;
  logic       busy;
  logic       wr_strobe;
  logic       err_overrun;
  logic       err_read;

  lcd_bus_receiver #(
    .SYNC_STAGES (S),
    .FILL_CHAR   (8'h20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .lcd_e       (lcd_e),
    .lcd_rs      (lcd_rs),
    .lcd_rw      (lcd_rw),
    .lcd_data    (lcd_data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .cursor      (cursor),
    .display_on  (display_on),
    .busy        (busy),
    .wr_strobe   (wr_strobe),
    .err_overrun (err_overrun),
    .err_read    (err_read)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the mirror as a transaction machine. Each bus transfer is
  // queued with the clock count at which it takes effect; the buffer is a
  // plain array with a "known" mask for locations never yet written.
  // ---------------------------------------------------------------------------
  typedef struct {
    int         exec;
    bit         rs;
    bit         rw;
    logic [7:0] d;
  } xfer_t;

  xfer_t      q[$];
  int         cyc = 0;
  bit         started = 0;
  logic [7:0] m_buf [32];
  bit         m_known [32];
  int         m_cursor;
  bit         m_disp, m_inc, m_busy, m_ovr, m_rderr, m_strobe;
  int         m_left;
  logic [7:0] m_rd;
  bit         m_rd_known;
  bit         was_busy;
  int         idx;
  int         a;
  xfer_t      x;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      started    = 1;
      m_cursor   = 0;
      m_disp     = 0;
      m_inc      = 1;
      m_busy     = 1;
      m_left     = 32;
      m_ovr      = 0;
      m_rderr    = 0;
      m_strobe   = 0;
      m_rd       = 8'h00;
      m_rd_known = 1;
      q.delete();
    end else if (started) begin
      was_busy   = m_busy;
      m_strobe   = 0;
      m_rd       = m_buf[rd_addr];
      m_rd_known = m_known[rd_addr];
      if (m_busy) begin
        idx          = 32 - m_left;
        m_buf[idx]   = 8'h20;
        m_known[idx] = 1;
        m_left--;
        if (m_left == 0) m_busy = 0;
      end
      if (q.size() > 0 && q[0].exec == cyc) begin
        x = q.pop_front();
        if (was_busy) begin
          m_ovr = 1;
        end else if (x.rw) begin
          m_rderr = 1;
        end else if (x.rs) begin
          m_buf[m_cursor]   = x.d;
          m_known[m_cursor] = 1;
          m_strobe          = 1;
          m_cursor          = (m_cursor + (m_inc ? 1 : 31)) % 32;
        end else if (x.d >= 8'h80) begin
          a = int'(x.d) - 128;
          if (a < 16) m_cursor = a;
          else if (a >= 64 && a < 80) m_cursor = 16 + (a - 64);
        end else if (x.d >= 8'h20) begin
          // function set: no effect
        end else if (x.d >= 8'h10) begin
          // shift: no effect
        end else if (x.d >= 8'h08) begin
          m_disp = x.d[2];
        end else if (x.d >= 8'h04) begin
          m_inc = x.d[1];
        end else if (x.d >= 8'h02) begin
          m_cursor = 0;
        end else if (x.d == 8'h01) begin
          m_cursor = 0;
          m_inc    = 1;
          m_busy   = 1;
          m_left   = 32;
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (started) begin
      chk("busy", busy, m_busy);
      chk("cursor", cursor, m_cursor);
      chk("display_on", display_on, m_disp);
      chk("wr_strobe", wr_strobe, m_strobe);
      chk("err_overrun", err_overrun, m_ovr);
      chk("err_read", err_read, m_rderr);
      if (m_rd_known) chk("rd_data", rd_data, m_rd);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all inputs change on the falling edge)
  // ---------------------------------------------------------------------------
  bit         pin = 0;
  logic [4:0] pin_addr = 5'd0;

  task automatic step();
    @(negedge clk);
    rd_addr = pin ? pin_addr : 5'($urandom_range(0, 31));
  endtask

  task automatic bus_xfer(input bit rs, input bit rw, input logic [7:0] d,
                          input bit strobe_chk, input int gap);
    xfer_t t;
    int    seen;
    $display("xfer rs=%0d rw=%0d data=%02h", rs, rw, d);
    step();
    lcd_rs   = rs;
    lcd_rw   = rw;
    lcd_data = d;
    lcd_e    = 1'b1;
    step();
    step();
    step();
    lcd_e  = 1'b0;
    t.exec = cyc + 1 + S + 1;
    t.rs   = rs;
    t.rw   = rw;
    t.d    = d;
    q.push_back(t);
    seen = 0;
    for (int k = 1; k <= S + 4; k++) begin
      step();
      if (wr_strobe && seen == 0) seen = k;
    end
    if (strobe_chk) chk("strobe_latency", seen, S + 2);
    repeat (gap) step();
  endtask

  task automatic read_lit(input logic [4:0] addr, input logic [7:0] req, input string name);
    pin      = 1;
    pin_addr = addr;
    step();
    @(posedge clk);
    #1;
    chk(name, rd_data, req);
    pin = 0;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  int         nbusy;
  logic [7:0] watch [5];
  int         r;

  initial begin
    watch[0] = 8'h57; watch[1] = 8'h41; watch[2] = 8'h54; watch[3] = 8'h43; watch[4] = 8'h48;

    // Reset and initial fill
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (34) step();
    chk("init_busy", busy, 0);
    chk("init_cursor", cursor, 0);
    chk("init_display_on", display_on, 0);
    chk("init_err_overrun", err_overrun, 0);
    chk("init_err_read", err_read, 0);
    for (int i = 0; i < 32; i++) read_lit(5'(i), 8'h20, "init_fill");

    // "WATCH"
    for (int i = 0; i < 5; i++) bus_xfer(1, 0, watch[i], 1, 2);
    for (int i = 0; i < 5; i++) read_lit(5'(i), watch[i], "watch_buf");
    chk("watch_cursor", cursor, 5);

    // Line 2 addressing, out-of-range address ignored
    bus_xfer(0, 0, 8'hC0, 0, 2);
    bus_xfer(1, 0, 8'h41, 1, 2);
    read_lit(5'd16, 8'h41, "line2_buf16");
    chk("line2_cursor", cursor, 17);
    bus_xfer(0, 0, 8'h90, 0, 2);
    chk("bad_addr_cursor", cursor, 17);

    // Decrement wrap, then increment across line boundary
    bus_xfer(0, 0, 8'h04, 0, 2);
    bus_xfer(0, 0, 8'h80, 0, 2);
    bus_xfer(1, 0, 8'h5A, 1, 2);
    read_lit(5'd0, 8'h5A, "dec_buf0");
    chk("dec_cursor", cursor, 31);
    bus_xfer(0, 0, 8'h06, 0, 2);
    bus_xfer(0, 0, 8'h8F, 0, 2);
    bus_xfer(1, 0, 8'h31, 1, 2);
    bus_xfer(1, 0, 8'h31, 1, 2);
    read_lit(5'd15, 8'h31, "inc_buf15");
    read_lit(5'd16, 8'h31, "inc_buf16");
    chk("inc_cursor", cursor, 17);

    // Display on
    bus_xfer(0, 0, 8'h0C, 0, 2);
    chk("display_on_set", display_on, 1);

    // Clear, then a data write during the fill is dropped
    bus_xfer(0, 0, 8'h01, 0, 10);
    bus_xfer(1, 0, 8'h41, 0, 0);
    chk("overrun_flag", err_overrun, 1);
    chk("overrun_cursor", cursor, 0);
    repeat (40) step();
    for (int i = 0; i < 32; i++) read_lit(5'(i), 8'h20, "clear_fill");

    // Reset in the middle of the fill restarts it
    do_reset();
    repeat (11) step();
    do_reset();
    nbusy = 0;
    for (int k = 0; k < 60; k++) begin
      if (!busy) break;
      nbusy++;
      step();
    end
    chk("reset_busy_cycles", nbusy, 32);
    chk("reset_err_overrun", err_overrun, 0);
    chk("reset_display_on", display_on, 0);

    // Read request: flagged, buffer untouched
    bus_xfer(1, 1, 8'h55, 0, 2);
    chk("read_flag", err_read, 1);
    read_lit(5'd0, 8'h20, "read_buf0");
    chk("read_cursor", cursor, 0);

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3)       bus_xfer(0, 0, 8'h01, 0, $urandom_range(0, 30));
      else if (r < 6)  bus_xfer($urandom_range(0, 1) == 1, 1, 8'($urandom_range(0, 255)), 0, $urandom_range(0, 30));
      else if (r < 55) bus_xfer(1, 0, 8'($urandom_range(32, 126)), 0, $urandom_range(0, 30));
      else if (r < 70) bus_xfer(0, 0, 8'($urandom_range(4, 15)), 0, $urandom_range(0, 30));
      else if (r < 85) bus_xfer(0, 0, 8'($urandom_range(0, 1) == 1 ? $urandom_range(8'hC0, 8'hCF) : $urandom_range(8'h80, 8'h8F)), 0, $urandom_range(0, 30));
      else             bus_xfer(0, 0, 8'($urandom_range(0, 255)), 0, $urandom_range(0, 30));
    end
    repeat (50) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
